mul_div_unit: RTL

Iterative multiply/divide unit with HI/LO result registers, sitting beside the EX-stage ALU of the pipelined CPU. Generalises the combinational ALU to a parametrised WIDTH with multi-cycle signed/unsigned MULT/DIV, MTHI/MTLO writes, and a start/busy/done handshake. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO. A `flush` input aborts an in-flight operation on a pipeline squash.

---
 rtl/mul_div_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a start/busy/done handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO are applied directly from here
// S_RUN  | iterating; counter counts WIDTH cycles down to 0
// S_DONE | one-cycle done pulse; hi/lo hold the new result; may accept
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   a_q, a_d;     // product upper half / partial remainder
    logic [WIDTH-1:0]   b_q, b_d;     // multiplier -> product lower half / dividend -> quotient
    logic [WIDTH-1:0]   m_q, m_d;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes and signs for the op being presented.
    logic               signed_op;
    logic               in1_neg, in2_neg;
    logic [WIDTH-1:0]   mag1, mag2;

    always_comb begin
        signed_op = ~op_i[0];
        in1_neg   = signed_op & in1_i[WIDTH-1];
        in2_neg   = signed_op & in2_i[WIDTH-1];
        mag1      = in1_neg ? -in1_i : in1_i;
        mag2      = in2_neg ? -in2_i : in2_i;
    end

    // One iteration of either datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_a, step_b;

    always_comb begin
        mul_sum   = {1'b0, a_q} + ({1'b0, m_q} & {(WIDTH+1){b_q[0]}});
        div_shift = {a_q, b_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        // Truncation is safe: when div_ge holds the difference is below the divisor.
        div_diff  = div_shift[WIDTH-1:0] - m_q;
        if (is_div_q) begin
            step_a = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_b = {b_q[WIDTH-2:0], div_ge};
        end else begin
            step_a = mul_sum[WIDTH:1];
            step_b = {mul_sum[0], b_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the final iteration's values.
    logic [2*WIDTH-1:0] prod_raw, prod_c;
    logic [WIDTH-1:0]   quo_c, rem_c;

    always_comb begin
        prod_raw = {step_a, step_b};
        prod_c   = neg_res_q ? -prod_raw : prod_raw;
        // A zero divisor leaves |in1| in the remainder, so re-signing restores in1.
        quo_c    = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? -step_b : step_b);
        rem_c    = neg_rem_q ? -step_a : step_a;
    end

    logic accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        accept    = start_i & ~flush_i & (state_q != S_RUN);

        case (state_q)
            S_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        if (is_div_q) begin
                            hi_d = rem_c;
                            lo_d = quo_c;
                        end else begin
                            hi_d = prod_c[2*WIDTH-1:WIDTH];
                            lo_d = prod_c[WIDTH-1:0];
                        end
                    end
                end
            end
            default: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    case (op_i)
                        OP_MTHI: hi_d = in1_i;
                        OP_MTLO: lo_d = in1_i;
                        OP_MULT, OP_MULTU: begin
                            state_d   = S_RUN;
                            cnt_d     = CNT_W'(WIDTH);
                            is_div_d  = 1'b0;
                            neg_res_d = in1_neg ^ in2_neg;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            a_d       = '0;
                            b_d       = mag2;
                            m_d       = mag1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_RUN;
                            cnt_d     = CNT_W'(WIDTH);
                            is_div_d  = 1'b1;
                            neg_res_d = in1_neg ^ in2_neg;
                            neg_rem_d = in1_neg;
                            dz_d      = (in2_i == '0);
                            a_d       = '0;
                            b_d       = mag1;
                            m_d       = mag2;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
